// File: rtl/sig_pkg.sv
// Shared lamp codes and phase encodings for the junction phase scheduler.
package sig_pkg;

   localparam logic [1:0] RED    = 2'd0;
   localparam logic [1:0] YELLOW = 2'd1;
   localparam logic [1:0] GREEN  = 2'd2;

   typedef enum logic [2:0] {
      HG   = 3'd0,
      HY   = 3'd1,
      AR1  = 3'd2,
      WALK = 3'd3,
      CG   = 3'd4,
      CY   = 3'd5,
      AR2  = 3'd6
   } state_e;

endpackage

// File: rtl/sig_phase_timer.sv
// Phase dwell counter: synchronous clear, increments every cycle, holds at all-ones.
module sig_phase_timer #(
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             srst,
   input  logic             clear_i,
   output logic [CNT_W-1:0] count_o
);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (count_q != '1) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/sig_phase_sched.sv
// Highway/country junction phase scheduler with pedestrian walk phase.
// Moore outputs decoded from the state register; dwell times counted in clock cycles.
module sig_phase_sched
   import sig_pkg::*;
#(
   parameter int Y2R_CYC     = 3,
   parameter int R2G_CYC     = 2,
   parameter int MIN_GRN_CYC = 8,
   parameter int MAX_CNT_CYC = 16,
   parameter int WALK_CYC    = 6,
   parameter int CNT_W       = 5
) (
   input  logic       clk,
   input  logic       clr,
   input  logic       x,
   input  logic       ped_req,
   output logic [1:0] hwy,
   output logic [1:0] cntry,
   output logic       walk,
   output logic       ped_ack,
   output logic [2:0] state
);

   state_e           state_q;
   state_e           state_d;
   logic             pend_q;
   logic             pend_d;
   logic [CNT_W-1:0] tmr;

   // True on the last cycle of an n-cycle dwell.
   function automatic logic done(input logic [CNT_W-1:0] t, input int n);
      return t == CNT_W'(n - 1);
   endfunction

   sig_phase_timer #(.CNT_W(CNT_W)) u_timer (
      .clk     (clk),
      .srst    (clr),
      .clear_i (state_d != state_q),
      .count_o (tmr)
   );

   assign ped_ack = (state_q == WALK) && (tmr == '0);
   assign pend_d  = ped_req | (pend_q & ~ped_ack);

   always_comb begin
      state_d = state_q;
      case (state_q)
         HG:   if ((tmr >= CNT_W'(MIN_GRN_CYC - 1)) && (x || pend_q)) state_d = HY;
         HY:   if (done(tmr, Y2R_CYC)) state_d = AR1;
         AR1:  if (done(tmr, R2G_CYC)) state_d = pend_q ? WALK : CG;
         WALK: if (done(tmr, WALK_CYC)) state_d = x ? CG : AR2;
         CG:   if (!x || done(tmr, MAX_CNT_CYC)) state_d = CY;
         CY:   if (done(tmr, Y2R_CYC)) state_d = AR2;
         AR2:  if (done(tmr, R2G_CYC)) state_d = HG;
         default: state_d = HG;
      endcase
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state_q <= HG;
         pend_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
      end
   end

   // Unused encodings show all-red for the single cycle before HG.
   always_comb begin
      hwy   = RED;
      cntry = RED;
      walk  = 1'b0;
      case (state_q)
         HG:   hwy   = GREEN;
         HY:   hwy   = YELLOW;
         WALK: walk  = 1'b1;
         CG:   cntry = GREEN;
         CY:   cntry = YELLOW;
         default: ;
      endcase
   end

   assign state = state_q;

endmodule
